// File: rtl/stack_ctrl.sv
// LIFO stack controller driving an external two-port memory (write/read port + read-only port).
// Optional STACK_CTRL_ERR_EN: sticky err flag raised by rejected PUSH-when-full / POP-TOP-when-empty.
module stack_ctrl #(
    parameter int N           = 1024,
    parameter int M           = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int IND_SIZE    = $clog2(N)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                op_valid,
    input  logic [1:0]          op,
    input  logic [M-1:0]        op_data,
    output logic                op_ready,
    output logic                done,
    output logic [M-1:0]        res_data,
    output logic                full,
    output logic                empty,
    output logic                err,
    output logic [IND_SIZE-1:0] mem_ind1,
    output logic [IND_SIZE-1:0] mem_ind2,
    output logic [M-1:0]        mem_in,
    output logic                mem_beta,
    input  logic [M-1:0]        mem_out2
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_TOP  = 2'b10;

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, DONE} state_t;

    state_t              state_q;
    logic [IND_SIZE:0]   sp_q;
    logic [IND_SIZE:0]   sp_m1;
    logic [M-1:0]        data_q;
    logic [M-1:0]        res_q;
    logic [CW-1:0]       cnt_q;
    logic                is_pop_q;
    logic                err_q;

    assign full     = (sp_q == (IND_SIZE+1)'(N));
    assign empty    = (sp_q == '0);
    assign sp_m1    = sp_q - 1'b1;
    // Addresses track sp continuously; sp only moves on exit edges, so they stay stable within an op.
    assign mem_ind1 = sp_q[IND_SIZE-1:0];
    assign mem_ind2 = sp_m1[IND_SIZE-1:0];
    assign mem_in   = data_q;
    assign mem_beta = (state_q == WRITE);
    assign op_ready = (state_q == IDLE);
    assign done     = (state_q == DONE);
    assign res_data = res_q;

`ifdef STACK_CTRL_ERR_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sp_q     <= '0;
            data_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            is_pop_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        cnt_q    <= '0;
                        is_pop_q <= (op == OP_POP);
                        state_q  <= DONE;
                        if (op == OP_PUSH) begin
                            if (!full) begin
                                data_q  <= op_data;
                                state_q <= WRITE;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else if (op == OP_POP || op == OP_TOP) begin
                            if (!empty) state_q <= READ_WAIT;
                            else        err_q   <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    sp_q    <= sp_q + 1'b1;
                    state_q <= DONE;
                end
                READ_WAIT: begin
                    if (cnt_q == CW'(WAIT_CYCLES-1)) begin
                        res_q   <= mem_out2;
                        if (is_pop_q) sp_q <= sp_m1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef STACK_CTRL_ERR_EN
    // err_q is only observable when the error feature is built in.
    logic unused_err;
    assign unused_err = err_q;
`endif
endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl (N=4, WAIT_CYCLES=2) with a behavioural memory and a result scoreboard.
module tb_stack_ctrl;
    localparam int N  = 4;
    localparam int M  = 32;
    localparam int W  = 2;
    localparam int IW = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          op_valid;
    logic [1:0]    op;
    logic [M-1:0]  op_data;
    logic          op_ready, done, full, empty, err, mem_beta;
    logic [M-1:0]  res_data, mem_in, mem_out2;
    logic [IW-1:0] mem_ind1, mem_ind2;

    stack_ctrl #(.N(N), .M(M), .WAIT_CYCLES(W), .IND_SIZE(IW)) dut (
        .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .op(op), .op_data(op_data),
        .op_ready(op_ready), .done(done), .res_data(res_data), .full(full), .empty(empty),
        .err(err), .mem_ind1(mem_ind1), .mem_ind2(mem_ind2), .mem_in(mem_in),
        .mem_beta(mem_beta), .mem_out2(mem_out2)
    );

    always #5 clock = ~clock;

    // Memory: one register stage on the read port gives a 2-cycle address-to-sample latency.
    logic [M-1:0] mem [N];
    logic [M-1:0] rd_q = '0;
    always @(posedge clock) begin
        if (mem_beta) mem[mem_ind1] <= mem_in;
        rd_q <= mem[mem_ind2];
    end
    assign mem_out2 = rd_q;

    typedef struct packed {
        logic [M-1:0] res;
        logic         e;
        logic         f;
        logic         em;
    } exp_t;

    exp_t         sbq[$];
    logic [M-1:0] mstk[$];
    logic [M-1:0] mres;
    logic         merr;
    int tests = 0, fails = 0, wr_cnt = 0, acc_cnt = 0;

    task automatic check(input string tag, input logic [M-1:0] act, input logic [M-1:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mem_beta) wr_cnt++;
        if (reset_n && op_valid && op_ready) acc_cnt++;
    end

    always @(negedge clock) begin
        if (reset_n && done) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_done", 32'(sbq.size()), 32'd1);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_res",   res_data, e.res);
                check("sb_err",   32'(err),   32'(e.e));
                check("sb_full",  32'(full),  32'(e.f));
                check("sb_empty", 32'(empty), 32'(e.em));
            end
        end
    end

    // Reference model: updates the stack at accept, queues the expected completion state.
    function automatic int model(input logic [1:0] o, input logic [M-1:0] d, output int wr);
        exp_t e;
        int   lat = 0;
        logic rej = 1'b0;
        wr = 0;
        case (o)
            2'b00: if (mstk.size() < N) begin mstk.push_back(d); lat = 1; wr = 1; end else rej = 1'b1;
            2'b01: if (mstk.size() > 0) begin mres = mstk.pop_back(); lat = W; end else rej = 1'b1;
            2'b10: if (mstk.size() > 0) begin mres = mstk[$]; lat = W; end else rej = 1'b1;
            default: ;
        endcase
`ifdef STACK_CTRL_ERR_EN
        if (rej) merr = 1'b1;
`else
        if (rej) merr = 1'b0;
`endif
        e.res = mres; e.e = merr; e.f = (mstk.size() == N); e.em = (mstk.size() == 0);
        sbq.push_back(e);
        return lat;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!op_ready && n < 100) begin @(posedge clock); #1; n++; end
        check({tag, "_ready"}, 32'(op_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [M-1:0] d);
        int lat, exp_lat, exp_wr;
        @(posedge clock); #1;
        op_valid = 1'b1; op = o; op_data = d;
        wait_ready(tag);
        @(posedge clock);
        exp_lat = model(o, d, exp_wr);
        wr_cnt = 0;
        #1 op_valid = 1'b0; op = 2'b11;
        lat = 0;
        @(negedge clock);
        while (!done && lat < 50) begin lat++; @(negedge clock); end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        @(negedge clock);
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(exp_wr));
    endtask

    task automatic do_reset();
        @(posedge clock); #1 reset_n = 1'b0;
        mstk.delete(); sbq.delete(); mres = '0; merr = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc0, dummy;
        reset_n = 1'b0; op_valid = 1'b0; op = 2'b11; op_data = '0; mres = '0; merr = 1'b0;
        #12;
        check("rst_ready", 32'(op_ready), 32'd1);
        check("rst_done",  32'(done),     32'd0);
        check("rst_res",   res_data,      32'd0);
        check("rst_err",   32'(err),      32'd0);
        check("rst_beta",  32'(mem_beta), 32'd0);
        check("rst_in",    mem_in,        32'd0);
        check("rst_empty", 32'(empty),    32'd1);
        check("rst_full",  32'(full),     32'd0);
        @(posedge clock); #1 reset_n = 1'b1;

        run_op("pop_empty", 2'b01, '0);
        do_reset();

        run_op("push_a5", 2'b00, 32'hA5A5A5A5);
        run_op("push_12", 2'b00, 32'h12345678);
        run_op("pop_12", 2'b01, '0);
        check("sp_after_pop", 32'(mem_ind1), 32'd1);
        run_op("top_a5", 2'b10, '0);
        check("sp_after_top", 32'(mem_ind1), 32'd1);
        run_op("nop", 2'b11, '0);

        for (int i = 0; i < 3; i++) run_op("fill", 2'b00, 32'hC0DE0000 + 32'(i));
        check("full_set", 32'(full), 32'd1);
        run_op("push_full", 2'b00, 32'hDEADBEEF);
        check("full_hold", 32'(full), 32'd1);
        check("sp_full", 32'(mem_ind1), 32'd0);
        for (int i = 0; i < 4; i++) run_op("drain", 2'b01, '0);
        check("drained", 32'(empty), 32'd1);

        run_op("push_77", 2'b00, 32'h00000077);
        @(posedge clock); #1;
        acc0 = acc_cnt;
        op_valid = 1'b1; op = 2'b01;
        wait_ready("held_pop");
        @(posedge clock);
        dummy = model(2'b01, '0, dummy);
        #1 op = 2'b00; op_data = 32'h00000099;
        wait_ready("held_push");
        @(posedge clock);
        dummy = model(2'b00, 32'h00000099, dummy);
        #1 op_valid = 1'b0; op = 2'b11;
        repeat (6) @(negedge clock);
        check("held_accepts", 32'(acc_cnt - acc0), 32'd2);
        check("held_sb_drained", 32'(sbq.size()), 32'd0);
        check("held_sp", 32'(mem_ind1), 32'd1);

        @(posedge clock); #1 op_valid = 1'b1; op = 2'b01;
        wait_ready("abort_pop");
        @(posedge clock); #1 op_valid = 1'b0; op = 2'b11;
        @(negedge clock);
        check("abort_busy", 32'(op_ready), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check("abort_ready", 32'(op_ready), 32'd1);
        check("abort_empty", 32'(empty),    32'd1);
        check("abort_done",  32'(done),     32'd0);
        mstk.delete(); sbq.delete(); mres = '0; merr = 1'b0;
        for (int i = 0; i < 3; i++) begin @(negedge clock); check("abort_no_done_rst", 32'(done), 32'd0); end
        @(posedge clock); #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin @(negedge clock); check("abort_no_done", 32'(done), 32'd0); end
        check("abort_res", res_data, 32'd0);

        run_op("post_push", 2'b00, 32'h0000C3C3);
        run_op("post_pop",  2'b01, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
